// File: rtl/rd_capture_fifo.sv
// rd_capture_fifo: captures one rw_reg read sample per read phase (rw high
// then low) into a small first-word-fall-through FIFO. It also keeps a running
// sum of accepted samples and a saturating count of samples dropped on overflow.
module rd_capture_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int SUMW  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rw,
    input  logic [WIDTH-1:0] read_in,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic [AW:0]      count,
    output logic [SUMW-1:0]  sum,
    output logic [7:0]       drop_cnt
);

    typedef enum logic [1:0] {HOLD, WPH, SETTLE, CAPT} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop_ok;
    logic             push_ok;
    logic             drop;

    // The push strobe decodes from registered state only, so rw never reaches an output
    assign push    = (state == CAPT);
    assign pop_ok  = pop && valid;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = valid ? mem[rd_ptr] : '0;

    // Capture sequencer: wait for a write phase, then take one sample per read phase
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            case (state)
                HOLD:    if (rw) state <= WPH;
                WPH:     if (!rw) state <= SETTLE;
                // rw_reg read output is registered; give it one cycle to settle
                SETTLE:  state <= rw ? WPH : CAPT;
                CAPT:    state <= rw ? WPH : HOLD;
                default: state <= HOLD;
            endcase
        end
    end

    // Storage write; contents are don't-care after reset, so there is no reset here
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= read_in;
    end

    // Pointers, occupancy, running sum and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sum      <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                sum    <= sum + SUMW'(read_in);
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rd_capture_fifo.sv
// Bench for rd_capture_fifo: directed read phases with hand-computed results.
// The stimulus pushes the expected sample into a scoreboard queue whenever it
// expects a capture to be accepted. An independent monitor pops the queue and
// compares dout on every cycle the consumer takes an entry.
module tb_rd_capture_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw;
    logic [15:0] read_in;
    logic        pop;
    logic [15:0] dout;
    logic        valid;
    logic        full;
    logic [2:0]  count;
    logic [19:0] sum;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];

    rd_capture_fifo #(.WIDTH(16), .DEPTH(4), .AW(2), .SUMW(20)) dut (
        .clk(clk), .rst(rst), .rw(rw), .read_in(read_in), .pop(pop),
        .dout(dout), .valid(valid), .full(full), .count(count),
        .sum(sum), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read phase: a write-phase cycle, then `low` cycles of rw=0 holding
    // `d` on read_in. With low>=3 the capture edge is the third low cycle.
    task automatic read_phase(input logic [15:0] d, input int low,
                              input bit acc, input bit pop_capt);
        rw = 1'b1; read_in = d;
        tick();
        rw = 1'b0;
        if (acc) exp_q.push_back(d);
        for (int i = 0; i < low; i++) begin
            if (i == 2) pop = pop_capt;
            tick();
            pop = 1'b0;
        end
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: whenever the consumer takes the head, it must match the scoreboard
    always @(negedge clk) begin
        if (!rst && pop && valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pop_head: got %0d, expected nothing queued", dout);
            end else begin
                chk("pop_head", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b0; rw = 1'b0; read_in = '0; pop = 1'b0;
        do_reset(2);
        chk("rst_count", count, 0);
        chk("rst_valid", valid, 0);
        chk("rst_full", full, 0);
        chk("rst_dout", dout, 0);
        chk("rst_sum", sum, 0);
        chk("rst_drop", drop_cnt, 0);
        // rw low straight out of reset must not capture
        repeat (3) tick();
        chk("no_cap_before_wph", count, 0);

        // Reset then capture; extra low cycles give no second push
        read_phase(16'd1, 5, 1'b1, 1'b0);
        chk("cap1_count", count, 1);
        chk("cap1_valid", valid, 1);
        chk("cap1_dout", dout, 1);
        chk("cap1_sum", sum, 1);

        // Two read phases
        read_phase(16'd55, 3, 1'b1, 1'b0);
        chk("two_count", count, 2);
        chk("two_sum", sum, 56);
        do_pop();
        chk("pop1_dout", dout, 55);
        chk("pop1_count", count, 1);
        do_pop();
        chk("pop2_valid", valid, 0);
        chk("pop2_dout", dout, 0);
        do_pop();
        chk("underflow_count", count, 0);

        // Aborted read: only one low cycle
        rw = 1'b1; read_in = 16'd99; tick();
        rw = 1'b0; tick();
        rw = 1'b1; tick(); tick();
        chk("abort_count", count, 0);
        chk("abort_sum", sum, 56);
        rw = 1'b0; tick();

        // Overflow from a clean state
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            read_phase(16'(10 + k), 3, (k < 4), 1'b0);
            if (k == 3) begin
                chk("ovf_full4", full, 1);
                chk("ovf_count4", count, 4);
            end
        end
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_sum", sum, 46);
        repeat (4) do_pop();
        chk("ovf_drained", valid, 0);

        // Push with simultaneous pop while full
        for (int k = 0; k < 4; k++) read_phase(16'(10 + k), 3, 1'b1, 1'b0);
        chk("pp_full", full, 1);
        read_phase(16'd20, 3, 1'b1, 1'b1);
        chk("pp_count", count, 4);
        chk("pp_drop", drop_cnt, 2);
        chk("pp_sum", sum, 112);
        repeat (4) do_pop();
        chk("pp_empty", count, 0);

        // Reset mid-operation with the sequencer in SETTLE
        read_phase(16'd30, 3, 1'b1, 1'b0);
        read_phase(16'd31, 3, 1'b1, 1'b0);
        chk("mid_pre_count", count, 2);
        rw = 1'b1; tick();
        rw = 1'b0; tick();
        do_reset(1);
        chk("mid_count", count, 0);
        chk("mid_sum", sum, 0);
        chk("mid_drop", drop_cnt, 0);
        chk("mid_valid", valid, 0);
        repeat (4) tick();
        chk("mid_no_cap", count, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
